cpu_decode_stage: RTL

Pipeline stage directly downstream of instruction fetch and upstream of execute. It detects each new fetched instruction by its tag changing, decodes the RV32I base encoding and registers the result for execute. A one-entry skid buffer keeps the stall output registered without losing the instruction that fetch presents during the cycle execute stalls.

---
 rtl/cpu_decode_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cpu_decode_stage.sv
// rtl/cpu_decode_stage.sv - RV32I decode stage with tag-change handshake and one-entry skid buffer
module cpu_decode_stage #(
    parameter int TAG_WIDTH = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [TAG_WIDTH-1:0] i_fetch_tag,
    input  logic [31:0]          i_fetch_instruction,
    input  logic [31:0]          i_fetch_pc,
    output logic                 o_busy,
    input  logic                 i_execute_busy,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic [31:0]          o_pc,
    output logic [31:0]          o_instruction,
    output logic [4:0]           o_rs1,
    output logic [4:0]           o_rs2,
    output logic [4:0]           o_rd,
    output logic                 o_rs1_used,
    output logic                 o_rs2_used,
    output logic                 o_rd_used,
    output logic [31:0]          o_imm,
    output logic                 o_is_lui,
    output logic                 o_is_auipc,
    output logic                 o_is_jal,
    output logic                 o_is_jalr,
    output logic                 o_is_branch,
    output logic                 o_is_load,
    output logic                 o_is_store,
    output logic                 o_is_alu_imm,
    output logic                 o_is_alu_reg,
    output logic                 o_is_fence,
    output logic                 o_is_system,
    output logic                 o_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [31:0]          pc;
        logic [31:0]          instruction;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic                 rs1_used;
        logic                 rs2_used;
        logic                 rd_used;
        logic [31:0]          imm;
        logic                 is_lui;
        logic                 is_auipc;
        logic                 is_jal;
        logic                 is_jalr;
        logic                 is_branch;
        logic                 is_load;
        logic                 is_store;
        logic                 is_alu_imm;
        logic                 is_alu_reg;
        logic                 is_fence;
        logic                 is_system;
        logic                 illegal;
    } record_t;

    logic [TAG_WIDTH-1:0] r_last_tag;
    logic                 r_skid_valid;
    record_t              r_skid;
    record_t              r_out;
    record_t              w_dec;
    logic                 w_accept;
    logic [31:0]          w_ins;
    logic [31:0]          w_imm_i;
    logic [31:0]          w_imm_s;
    logic [31:0]          w_imm_b;
    logic [31:0]          w_imm_u;
    logic [31:0]          w_imm_j;

    assign w_ins    = i_fetch_instruction;
    assign w_imm_i  = {{20{w_ins[31]}}, w_ins[31:20]};
    assign w_imm_s  = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
    assign w_imm_b  = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
    assign w_imm_u  = {w_ins[31:12], 12'b0};
    assign w_imm_j  = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

    // A differing tag is a new instruction; nothing is taken while the skid holds one.
    assign w_accept = (i_fetch_tag != r_last_tag) && !r_skid_valid;

    // Decode the presented instruction into a full output record.
    always_comb begin
        w_dec             = '0;
        w_dec.tag         = i_fetch_tag;
        w_dec.pc          = i_fetch_pc;
        w_dec.instruction = w_ins;
        w_dec.rd          = w_ins[11:7];
        w_dec.rs1         = w_ins[19:15];
        w_dec.rs2         = w_ins[24:20];
        case (w_ins[6:0])
            OP_LUI:    begin w_dec.is_lui     = 1'b1; w_dec.imm = w_imm_u; end
            OP_AUIPC:  begin w_dec.is_auipc   = 1'b1; w_dec.imm = w_imm_u; end
            OP_JAL:    begin w_dec.is_jal     = 1'b1; w_dec.imm = w_imm_j; end
            OP_JALR:   begin w_dec.is_jalr    = 1'b1; w_dec.imm = w_imm_i; end
            OP_BRANCH: begin w_dec.is_branch  = 1'b1; w_dec.imm = w_imm_b; end
            OP_LOAD:   begin w_dec.is_load    = 1'b1; w_dec.imm = w_imm_i; end
            OP_STORE:  begin w_dec.is_store   = 1'b1; w_dec.imm = w_imm_s; end
            OP_IMM:    begin w_dec.is_alu_imm = 1'b1; w_dec.imm = w_imm_i; end
            OP_REG:    begin w_dec.is_alu_reg = 1'b1; end
            OP_FENCE:  begin w_dec.is_fence   = 1'b1; w_dec.imm = w_imm_i; end
            OP_SYSTEM: begin w_dec.is_system  = 1'b1; w_dec.imm = w_imm_i; end
            default:   begin w_dec.illegal    = 1'b1; end
        endcase
        w_dec.rs1_used = !(w_dec.is_lui || w_dec.is_auipc || w_dec.is_jal);
        w_dec.rs2_used = w_dec.is_branch || w_dec.is_store || w_dec.is_alu_reg;
        w_dec.rd_used  = !(w_dec.is_branch || w_dec.is_store || w_dec.is_fence)
                         && (w_dec.rd != 5'd0);
    end

    // Drain the skid first when execute frees up; otherwise route an accepted record
    // to the output or, while execute stalls, park it in the skid.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last_tag   <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
            r_out        <= '0;
        end else if (r_skid_valid) begin
            if (!i_execute_busy) begin
                r_out        <= r_skid;
                r_skid_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_last_tag <= i_fetch_tag;
            if (!i_execute_busy) begin
                r_out <= w_dec;
            end else begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign o_busy        = r_skid_valid;
    assign o_tag         = r_out.tag;
    assign o_pc          = r_out.pc;
    assign o_instruction = r_out.instruction;
    assign o_rs1         = r_out.rs1;
    assign o_rs2         = r_out.rs2;
    assign o_rd          = r_out.rd;
    assign o_rs1_used    = r_out.rs1_used;
    assign o_rs2_used    = r_out.rs2_used;
    assign o_rd_used     = r_out.rd_used;
    assign o_imm         = r_out.imm;
    assign o_is_lui      = r_out.is_lui;
    assign o_is_auipc    = r_out.is_auipc;
    assign o_is_jal      = r_out.is_jal;
    assign o_is_jalr     = r_out.is_jalr;
    assign o_is_branch   = r_out.is_branch;
    assign o_is_load     = r_out.is_load;
    assign o_is_store    = r_out.is_store;
    assign o_is_alu_imm  = r_out.is_alu_imm;
    assign o_is_alu_reg  = r_out.is_alu_reg;
    assign o_is_fence    = r_out.is_fence;
    assign o_is_system   = r_out.is_system;
    assign o_illegal     = r_out.illegal;

endmodule
